// File: rtl/mem_browser_pkg.sv
// Shared step-FSM encoding, default button timing and a counter sizing helper.
// The state set depends on MEM_BROWSER_AUTOREPEAT_EN.
package mem_browser_pkg;

    localparam int DEF_DEBOUNCE_CYC     = 1_000_000;
    localparam int DEF_REPEAT_DELAY_CYC = 50_000_000;
    localparam int DEF_REPEAT_RATE_CYC  = 10_000_000;

`ifdef MEM_BROWSER_AUTOREPEAT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_REPEAT = 2'd2} step_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PRESSED = 2'd1} step_state_t;
`endif

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_browser_btn_step.sv
// One pushbutton: 2-flop synchroniser, debouncer and step FSM.
// MEM_BROWSER_AUTOREPEAT_EN adds hold-to-repeat.
//   state      | meaning
//   ST_IDLE    | released, or held since reset and not yet re-pressed
//   ST_HOLD    | pressed, waiting out the first repeat delay
//   ST_REPEAT  | pressed, stepping every repeat interval
//   ST_PRESSED | pressed, single step already issued (no auto-repeat)
module btn_step
    import mem_browser_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic step_o,
    output logic level_o
);
    localparam int DB_W = cnt_w(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0] DB_INIT   = DB_W'(DEBOUNCE_CYC + 1);

    if (DEBOUNCE_CYC < 1 || REPEAT_DELAY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_bad_param
        $error("btn_step: timing parameters must be >= 1");
    end

    logic            sync1_q, sync2_q, samp_q, level_q, armed_q, step_q;
    logic [DB_W-1:0] db_cnt_q;
    step_state_t     state_q;
    logic            stable, rise, fall;

    assign stable  = (db_cnt_q == '0) && (sync2_q == samp_q);
    assign rise    = stable && samp_q && !level_q;
    assign fall    = stable && !samp_q && level_q;
    assign step_o  = step_q;
    assign level_o = level_q;

    // armed_q blocks the step for a button already held when reset was released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            samp_q   <= 1'b0;
            level_q  <= 1'b0;
            armed_q  <= 1'b0;
            db_cnt_q <= DB_INIT;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            samp_q  <= sync2_q;
            if (sync2_q != samp_q) begin
                db_cnt_q <= DB_RELOAD;
            end else if (db_cnt_q != '0) begin
                db_cnt_q <= db_cnt_q - 1'b1;
            end
            if (stable) begin
                level_q <= samp_q;
            end
            if (stable && !samp_q) begin
                armed_q <= 1'b1;
            end
        end
    end

`ifdef MEM_BROWSER_AUTOREPEAT_EN
    localparam int RP_W = cnt_w((REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                      : REPEAT_RATE_CYC);
    localparam logic [RP_W-1:0] RP_DELAY_LD = RP_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RP_W-1:0] RP_RATE_LD  = RP_W'(REPEAT_RATE_CYC - 1);

    logic [RP_W-1:0] rp_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            step_q   <= 1'b0;
            rp_cnt_q <= '0;
        end else begin
            step_q <= 1'b0;
            if (fall) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise && armed_q) begin
                            state_q  <= ST_HOLD;
                            step_q   <= 1'b1;
                            rp_cnt_q <= RP_DELAY_LD;
                        end
                    end
                    ST_HOLD, ST_REPEAT: begin
                        if (rp_cnt_q == '0) begin
                            state_q  <= ST_REPEAT;
                            step_q   <= 1'b1;
                            rp_cnt_q <= RP_RATE_LD;
                        end else begin
                            rp_cnt_q <= rp_cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            step_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if (fall) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise && armed_q) begin
                            state_q <= ST_PRESSED;
                            step_q  <= 1'b1;
                        end
                    end
                    ST_PRESSED: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
`endif

endmodule

// File: rtl/mem_browser.sv
// Button-driven RAM browser: write/read pointers, simple dual-port RAM, auto read refresh.
// MEM_BROWSER_AUTOREPEAT_EN enables hold-to-repeat on the pointer buttons.
module mem_browser
    import mem_browser_pkg::*;
#(
    parameter int DATA_W           = 16,
    parameter int ADDR_W           = 10,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
    parameter int WRAP             = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_inc,
    input  logic              wr_dec,
    input  logic              rd_inc,
    input  logic              rd_dec,
    input  logic              clr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_strobe
);
    logic [4:0] btn_raw, steps, level_unused;
    logic       step_wi, step_wd, step_ri, step_rd, step_clr;

    assign btn_raw = {clr, rd_dec, rd_inc, wr_dec, wr_inc};
    assign {step_clr, step_rd, step_ri, step_wd, step_wi} = steps;

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_step #(
            .DEBOUNCE_CYC    (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC (REPEAT_RATE_CYC)
        ) u_btn (
            .clk    (clk),
            .reset_n(reset_n),
            .btn_i  (btn_raw[i]),
            .step_o (steps[i]),
            .level_o(level_unused[i])
        );
    end

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, rd_req_q, init_q, we, rd_req;

    function automatic logic [ADDR_W-1:0] ptr_move(input logic [ADDR_W-1:0] p, input logic up);
        logic [ADDR_W-1:0] lim;
        lim = up ? '1 : '0;
        if (WRAP == 0 && p == lim) return p;
        return up ? p + 1'b1 : p - 1'b1;
    endfunction

    // inc and dec in the same cycle cancel: no move and, for the write side, no store
    always_comb begin
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        we      = 1'b0;
        if (step_clr) begin
            waddr_d = '0;
            raddr_d = '0;
        end else begin
            if (step_wi ^ step_wd) begin
                we      = 1'b1;
                waddr_d = ptr_move(waddr_q, step_wi);
            end
            if (step_ri ^ step_rd) begin
                raddr_d = ptr_move(raddr_q, step_ri);
            end
        end
    end

    assign rd_req = (|steps) | init_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr_q] <= wr_data;
        end
    end

    // Read lags the request by one cycle so it sees both the moved raddr and any fresh write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waddr_q    <= '0;
            raddr_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            init_q     <= 1'b1;
        end else begin
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            init_q     <= 1'b0;
            rd_req_q   <= rd_req;
            rd_valid_q <= rd_req_q;
            if (rd_req_q) begin
                rd_data_q <= mem_q[raddr_q];
            end
        end
    end

    assign waddr     = waddr_q;
    assign raddr     = raddr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_strobe = we;

endmodule

// File: tb/tb_mem_browser.sv
// Directed bench for mem_browser: a wrapping instance plus a saturating twin on the same buttons.
module tb_mem_browser;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam int B_WI = 0, B_WD = 1, B_RI = 2, B_RD = 3, B_CLR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n = 1'b0;
    logic          wr_inc = 1'b0, wr_dec = 1'b0, rd_inc = 1'b0, rd_dec = 1'b0, clr = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [AW-1:0] waddr_a, raddr_a, waddr_b, raddr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, wr_strobe_a, sat_rd_valid_unused, sat_wr_strobe_unused;

    mem_browser #(
        .DATA_W(DW), .ADDR_W(AW), .DEBOUNCE_CYC(DB),
        .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR), .WRAP(1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .wr_inc(wr_inc), .wr_dec(wr_dec), .rd_inc(rd_inc), .rd_dec(rd_dec), .clr(clr),
        .wr_data(wr_data), .waddr(waddr_a), .raddr(raddr_a), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .wr_strobe(wr_strobe_a)
    );

    mem_browser #(
        .DATA_W(DW), .ADDR_W(AW), .DEBOUNCE_CYC(DB),
        .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR), .WRAP(0)
    ) u_dut_sat (
        .clk(clk), .reset_n(reset_n),
        .wr_inc(wr_inc), .wr_dec(wr_dec), .rd_inc(rd_inc), .rd_dec(rd_dec), .clr(clr),
        .wr_data(wr_data), .waddr(waddr_b), .raddr(raddr_b), .rd_data(rd_data_b),
        .rd_valid(sat_rd_valid_unused), .wr_strobe(sat_wr_strobe_unused)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, ws_cnt = 0, ws_last = 0, rv_cnt = 0, rv_last = 0;
    always @(negedge clk) begin
        cyc++;
        if (wr_strobe_a === 1'b1) begin
            ws_cnt++;
            ws_last = cyc;
        end
        if (rd_valid_a === 1'b1) begin
            rv_cnt++;
            rv_last = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_WI:    wr_inc = v;
            B_WD:    wr_dec = v;
            B_RI:    rd_inc = v;
            B_RD:    rd_dec = v;
            default: clr    = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(10);
        set_btn(b, 1'b0);
        tick(12);
    endtask

    initial begin
        int b_ws, b_rv, lat;
        int stamps[$];
        int exp_off[5] = '{0, 20, 25, 30, 35};

        // reset state
        tick(2);
        check("rst_waddr", waddr_a, 0);
        check("rst_raddr", raddr_a, 0);
        check("rst_rd_data", rd_data_a, 0);
        check("rst_rd_valid", rd_valid_a, 0);
        check("rst_wr_strobe", wr_strobe_a, 0);
        reset_n = 1'b1;
        b_rv = rv_cnt;
        tick(12);
        check("init_refresh", rv_cnt - b_rv, 1);

        // single write
        wr_data = 16'hA5A5;
        b_ws = ws_cnt;
        b_rv = rv_cnt;
        lat = 0;
        wr_inc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (wr_strobe_a && lat == 0) lat = k;
        end
        wr_inc = 1'b0;
        tick(12);
        check("t1_latency_in_range", (lat >= DB + 1 && lat <= DB + 3), 1);
        check("t1_strobes", ws_cnt - b_ws, 1);
        check("t1_waddr", waddr_a, 1);
        check("t1_rd_valids", rv_cnt - b_rv, 1);
        check("t1_valid_lag", rv_last - ws_last, 2);
        check("t1_rd_data", rd_data_a, 16'hA5A5);

        // bounce rejection
        b_rv = rv_cnt;
        rd_inc = 1'b1; tick(3);
        rd_inc = 1'b0; tick(1);
        rd_inc = 1'b1; tick(3);
        rd_inc = 1'b0; tick(12);
        check("t2_raddr", raddr_a, 0);
        check("t2_no_refresh", rv_cnt - b_rv, 0);

        // wrap vs saturate
        press(B_RD);
        check("t3_wrap_low_a", raddr_a, 7);
        check("t3_sat_low_b", raddr_b, 0);
        repeat (7) press(B_RI);
        check("t3_walk_a", raddr_a, 6);
        check("t3_walk_b", raddr_b, 7);
        press(B_RI);
        check("t3_sat_high_b", raddr_b, 7);
        press(B_RI);
        check("t3_wrap_high_a", raddr_a, 0);
        check("t3_sat_hold_b", raddr_b, 7);

        // read-after-write at address 2
        wr_data = 16'h5555;
        press(B_WI);
        press(B_RI);
        press(B_RI);
        check("t4_waddr_pre", waddr_a, 2);
        check("t4_raddr_pre", raddr_a, 2);
        wr_data = 16'h1234;
        press(B_WI);
        check("t4_rd_data", rd_data_a, 16'h1234);
        check("t4_valid_lag", rv_last - ws_last, 2);
        check("t4_waddr_post", waddr_a, 3);
        press(B_RD);
        check("t4_old_word", rd_data_a, 16'h5555);

        // auto-repeat
        b_ws = ws_cnt;
        wr_inc = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 39) wr_inc = 1'b0;
            tick(1);
            if (wr_strobe_a) stamps.push_back(k);
        end
        tick(5);
`ifdef MEM_BROWSER_AUTOREPEAT_EN
        check("t5_step_count", stamps.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < stamps.size()) check($sformatf("t5_offset%0d", i), stamps[i] - stamps[0], exp_off[i]);
        end
        check("t5_waddr", waddr_a, 0);
`else
        check("t5_step_count", stamps.size(), 1);
        check("t5_waddr", waddr_a, 4);
`endif
        check("t5_strobes", ws_cnt - b_ws, stamps.size());

        // reset while repeating, button held through release
        rd_inc = 1'b1;
        tick(35);
        reset_n = 1'b0;
        #1;
        check("t6_rst_waddr", waddr_a, 0);
        check("t6_rst_raddr", raddr_a, 0);
        check("t6_rst_rd_data", rd_data_a, 0);
        check("t6_rst_rd_valid", rd_valid_a, 0);
        check("t6_rst_wr_strobe", wr_strobe_a, 0);
        tick(2);
        reset_n = 1'b1;
        b_rv = rv_cnt;
        tick(40);
        check("t6_held_no_step", raddr_a, 0);
        check("t6_init_only", rv_cnt - b_rv, 1);
        check("t6_ram_kept", rd_data_a, 16'hA5A5);
        rd_inc = 1'b0;
        tick(12);
        check("t6_release_no_step", raddr_a, 0);

        // write-then-decrement, also at the saturating limit
        wr_data = 16'h0F0F;
        b_ws = ws_cnt;
        press(B_WD);
        check("t6_dec_strobe", ws_cnt - b_ws, 1);
        check("t6_dec_waddr_a", waddr_a, 7);
        check("t6_dec_rd_a", rd_data_a, 16'h0F0F);
        check("t6_dec_waddr_b", waddr_b, 0);
        check("t6_dec_rd_b", rd_data_b, 16'h0F0F);

        // simultaneous inc+dec
        b_ws = ws_cnt;
        wr_inc = 1'b1; wr_dec = 1'b1;
        tick(10);
        wr_inc = 1'b0; wr_dec = 1'b0;
        tick(12);
        check("t6_wconf_nowrite", ws_cnt - b_ws, 0);
        check("t6_wconf_waddr", waddr_a, 7);
        b_rv = rv_cnt;
        rd_inc = 1'b1; rd_dec = 1'b1;
        tick(10);
        rd_inc = 1'b0; rd_dec = 1'b0;
        tick(12);
        check("t6_rconf_raddr", raddr_a, 0);
        check("t6_rconf_valid", rv_cnt - b_rv, 1);

        // clear
        b_ws = ws_cnt;
        b_rv = rv_cnt;
        press(B_CLR);
        check("clr_waddr", waddr_a, 0);
        check("clr_raddr", raddr_a, 0);
        check("clr_nowrite", ws_cnt - b_ws, 0);
        check("clr_refresh", rv_cnt - b_rv, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
